// File: rtl/shared_mem_responder.sv
// rtl/shared_mem_responder.sv - round-robin responder for four CPU memory requesters
module shared_mem_responder #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic                      clock,
    input  logic                      RESETn,
    input  logic [N_REQ-1:0]          REQ,
    input  logic [N_REQ-1:0]          RW,
    input  logic [N_REQ*ADDR_W-1:0]   ADDRESS,
    input  logic [N_REQ*DATA_W-1:0]   data_in,
    output logic [N_REQ-1:0]          ACK,
    output logic [DATA_W-1:0]         data_out,
    output logic                      ERR,
    output logic                      BUSY
);

    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic [1:0]        state;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  grant_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  probe;
    logic              grant_found;
    logic              addr_ok;

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        probe       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            probe = PTR_W'((int'(ptr) + k) % N_REQ);
            if (!grant_found && REQ[probe]) begin
                grant_idx   = probe;
                grant_found = 1'b1;
            end
        end
    end

    assign addr_ok = (int'(addr_q) < DEPTH);

    always_ff @(posedge clock or negedge RESETn) begin
        if (!RESETn) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            grant_q  <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ACK      <= '0;
            data_out <= '0;
            ERR      <= 1'b0;
            BUSY     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        grant_q <= grant_idx;
                        rw_q    <= RW[grant_idx];
                        addr_q  <= ADDRESS[grant_idx*ADDR_W +: ADDR_W];
                        wdata_q <= data_in[grant_idx*DATA_W +: DATA_W];
                        ptr     <= PTR_W'((int'(grant_idx) + 1) % N_REQ);
                        BUSY    <= 1'b1;
                        state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!addr_ok) begin
                        data_out <= '0;
                        ERR      <= 1'b1;
                    end else if (rw_q) begin
                        mem[addr_q[MEM_AW-1:0]] <= wdata_q;
                    end else begin
                        data_out <= mem[addr_q[MEM_AW-1:0]];
                    end
                    ACK          <= '0;
                    ACK[grant_q] <= 1'b1;
                    state        <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Response stays frozen until the granted CPU withdraws its request.
                    if (!REQ[grant_q]) begin
                        ACK   <= '0;
                        ERR   <= 1'b0;
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
